// File: rtl/op_mode_ctrl.sv
// op_mode_ctrl: UART frame parser that sets the signal-generator mode/factor and returns an ACK/NAK/status byte
module op_mode_ctrl #(
  parameter int          TIMEOUT_CYC = 100000,
  parameter int          FLAG_W      = 4,
  parameter logic [15:0] FACTOR_RST  = 16'd2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [2:0]  o_mode,
  output logic [15:0] o_factor,
  output logic        o_flag,
  output logic        o_busy,
  output logic        o_timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int FW = $clog2(FLAG_W + 1);
  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DHI, S_DLO, S_CHK, S_EXEC, S_RESP} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_cmd, r_dhi, r_dlo, r_chk, r_tx_data;
  logic [TW-1:0] r_tcnt;
  logic [FW-1:0] r_fcnt;
  logic          r_tx_valid, r_terr, r_fstart;
  logic [2:0]    r_mode;
  logic [15:0]   r_factor;
  logic          w_in_frame, w_abort, w_exec, w_chk_ok, w_set_mode, w_set_fac, w_status;
  logic [15:0]   w_d;
  logic [7:0]    w_reply;
  assign w_d        = {r_dhi, r_dlo};
  assign w_in_frame = r_state inside {S_CMD, S_DHI, S_DLO, S_CHK};
  assign w_exec     = r_state == S_EXEC;
  assign w_chk_ok   = r_chk == (r_cmd ^ r_dhi ^ r_dlo);
  assign w_set_mode = w_chk_ok && r_cmd == 8'h01 && w_d < 16'd3;
  assign w_set_fac  = w_chk_ok && r_cmd == 8'h02 && w_d != 16'd0;
  assign w_status   = w_chk_ok && r_cmd == 8'h03;
  assign w_reply    = w_status ? {5'b0, r_mode} : (w_set_mode || w_set_fac) ? ACK : NAK;
  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = r_tx_valid;
  assign o_mode        = r_mode;
  assign o_factor      = r_factor;
  assign o_flag        = r_fcnt != '0;
  assign o_busy        = r_state != S_IDLE;
  assign o_timeout_err = r_terr;
  // Next state: one byte per rx_valid; an idle terminal-count cycle aborts, but a byte on that cycle wins
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:  w_next = (i_rx_valid && i_rx_data == SOF) ? S_CMD : S_IDLE;
      S_CMD:   w_next = i_rx_valid ? S_DHI : S_CMD;
      S_DHI:   w_next = i_rx_valid ? S_DLO : S_DHI;
      S_DLO:   w_next = i_rx_valid ? S_CHK : S_DLO;
      S_CHK:   w_next = i_rx_valid ? S_EXEC : S_CHK;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  w_next = (r_tx_valid && i_tx_ready) ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
    if (w_in_frame && !i_rx_valid && r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
      w_next  = S_IDLE;
      w_abort = 1'b1;
    end
  end
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  // Inter-byte timeout counter, cleared by any accepted byte and outside the frame-collecting states
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else begin
      r_tcnt <= (w_in_frame && !i_rx_valid && !w_abort) ? r_tcnt + TW'(1) : '0;
      r_terr <= w_abort;
    end
  // Frame field capture
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cmd <= '0;
      r_dhi <= '0;
      r_dlo <= '0;
      r_chk <= '0;
    end else if (i_rx_valid) begin
      r_cmd <= r_state == S_CMD ? i_rx_data : r_cmd;
      r_dhi <= r_state == S_DHI ? i_rx_data : r_dhi;
      r_dlo <= r_state == S_DLO ? i_rx_data : r_dlo;
      r_chk <= r_state == S_CHK ? i_rx_data : r_chk;
    end
  // Mode and factor change only in the single EXEC cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_mode   <= 3'b000;
      r_factor <= FACTOR_RST;
    end else if (w_exec) begin
      r_mode   <= w_set_mode ? w_d[2:0] : r_mode;
      r_factor <= w_set_fac ? w_d : r_factor;
    end
  // Reply byte registered on entry to RESP and held until the transmitter takes it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_exec) begin
      r_tx_data  <= w_reply;
      r_tx_valid <= 1'b1;
    end else if (r_tx_valid && i_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  // Flag pulse starts one cycle after the factor update so the factor is settled first; a running pulse is never restarted
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_fstart <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_fstart <= w_exec && w_set_fac;
      r_fcnt   <= (r_fstart && r_fcnt == '0) ? FW'(FLAG_W) : (r_fcnt != '0) ? r_fcnt - FW'(1) : r_fcnt;
    end
endmodule

// File: tb/tb_op_mode_ctrl.sv
// tb_op_mode_ctrl: randomized scoreboard bench for op_mode_ctrl against a frame-level reference model
module tb_op_mode_ctrl;
  localparam int TO = 32;
  localparam int FW = 4;
  typedef struct {
    bit          to;
    logic [7:0]  rep;
    logic [2:0]  mode;
    logic [15:0] fac;
  } exp_t;
  logic        clk = 0, rst_n = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_valid = 0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [2:0]  mode;
  logic [15:0] factor;
  logic        flag, busy, terr;
  logic        rr = 0, fixed_ready = 1, rnd = 1;
  int          vec = 0, mis = 0;
  exp_t        q[$];
  logic [2:0]  m_mode = 0;
  logic [15:0] m_fac = 16'd2;
  int          exp_flags = 0, flags = 0;
  assign tx_ready = rr ? rnd : fixed_ready;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 rnd = 1'($urandom_range(0, 1));
  end
  op_mode_ctrl #(.TIMEOUT_CYC(TO), .FLAG_W(FW), .FACTOR_RST(16'd2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_mode(mode), .o_factor(factor), .o_flag(flag), .o_busy(busy), .o_timeout_err(terr)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask
  function automatic exp_t model(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
    exp_t e;
    int   d = {h, l};
    e.to = 0;
    if (k != (c ^ h ^ l)) e.rep = 8'h15;
    else if (c == 1 && d <= 2) begin
      m_mode = 3'(d);
      e.rep = 8'h06;
    end else if (c == 2 && d != 0) begin
      m_fac = 16'(d);
      exp_flags++;
      e.rep = 8'h06;
    end else if (c == 3) e.rep = {5'b0, m_mode};
    else e.rep = 8'h15;
    e.mode = m_mode;
    e.fac  = m_fac;
    return e;
  endfunction
  int          cyc = 0, chg_cyc = -10, run = 0;
  logic [15:0] pf = 16'd2;
  logic        pflag = 0;
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    cyc++;
    if (factor !== pf) chg_cyc = cyc;
    pf = factor;
    if (flag && !pflag) begin
      flags++;
      chk("flag_after_factor", 32'(cyc - chg_cyc), 1);
    end
    if (flag) run++;
    else if (pflag) begin
      chk("flag_width", 32'(run), FW);
      run = 0;
    end
    pflag = flag;
    if ((tx_valid && tx_ready) || terr) begin
      if (q.size() == 0) chk("unexpected_event", {tx_valid, terr}, 0);
      else begin
        e = q.pop_front();
        chk("timeout_event", terr, e.to);
        if (!e.to) begin
          chk("tx_data", tx_data, e.rep);
          chk("mode", mode, e.mode);
          chk("factor", factor, e.fac);
        end
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1;
    @(posedge clk);
    #1 rx_valid = 0;
  endtask
  task automatic gap(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 500) chk("done_timeout", {q.size() != 0, busy}, 0);
  endtask
  task automatic frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k, input int mg);
    q.push_back(model(c, h, l, k));
    send_byte(8'hA5); gap($urandom_range(0, mg));
    send_byte(c);     gap($urandom_range(0, mg));
    send_byte(h);     gap($urandom_range(0, mg));
    send_byte(l);     gap($urandom_range(0, mg));
    send_byte(k);
    wait_done();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vec=%0d", vec);
    $fatal(1);
  end
  initial begin
    exp_t        t;
    logic [7:0]  d0, c, h, l, k, b;
    logic        stable;
    int          n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mode", mode, 0);
    chk("rst_factor", factor, 2);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_flag", flag, 0);
    rst_n = 1;
    gap(2);
    send_byte(8'hA5);
    send_byte(8'h02);
    #3 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mode", mode, 0);
    chk("midrst_factor", factor, 2);
    chk("midrst_tx_valid", tx_valid, 0);
    @(posedge clk);
    #1 rst_n = 1;
    frame(8'h03, 8'h00, 8'h00, 8'h03, 2);
    frame(8'h02, 8'h01, 8'hF4, 8'hF7, 0);
    gap(8);
    frame(8'h02, 8'h00, 8'h00, 8'h02, 1);
    frame(8'h01, 8'h00, 8'h05, 8'h05, 1);
    frame(8'h01, 8'h00, 8'h02, 8'h03, 1);
    frame(8'h03, 8'h00, 8'h00, 8'h03, 1);
    t.to = 1;
    q.push_back(t);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    gap(TO);
    wait_done();
    chk("to_busy", busy, 0);
    chk("to_tx_valid", tx_valid, 0);
    q.push_back(model(8'h01, 8'h00, 8'h01, 8'h00));
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    gap(TO - 1);
    send_byte(8'h01);
    gap(TO - 1);
    send_byte(8'h00);
    wait_done();
    fixed_ready = 0;
    q.push_back(model(8'h03, 8'h00, 8'h00, 8'h03));
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    n = 0;
    while (!tx_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk("hold_tx_valid_rise", tx_valid, 1);
    d0 = tx_data;
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      rx_data  = 8'hA5;
      rx_valid = (i % 7 == 0);
      @(posedge clk);
      #1;
      if (!tx_valid || tx_data !== d0) stable = 0;
    end
    rx_valid = 0;
    chk("hold_stable", stable, 1);
    chk("hold_busy", busy, 1);
    fixed_ready = 1;
    @(posedge clk);
    #1;
    chk("idle_after_ready", busy, 0);
    chk("tx_valid_after_ready", tx_valid, 0);
    frame(8'h03, 8'h00, 8'h00, 8'h03, 1);
    rr = 1;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      if ($urandom_range(0, 2) == 0) send_byte(b);
      case ($urandom_range(0, 3))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        default: c = 8'($urandom);
      endcase
      h = 8'($urandom);
      l = 8'($urandom);
      if (c == 8'h01 && $urandom_range(0, 1) == 0) begin
        h = 0;
        l = 8'($urandom_range(0, 4));
      end
      if (c == 8'h02 && $urandom_range(0, 4) == 0) {h, l} = 16'd0;
      if (c == 8'h02 && {h, l} == m_fac) {h, l} = m_fac + 16'd1;
      k = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (c ^ h ^ l);
      frame(c, h, l, k, 3);
      gap(FW + 2);
    end
    rr = 0;
    gap(FW + 4);
    chk("flag_count", 32'(flags), 32'(exp_flags));
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
